thread_mem_responder: RTL and testbench

- Memory-side responder for the two-thread pipelined stack processor's load/store/fetch port.
- Accepts read and write requests tagged with a thread ID over a valid/ready handshake.
- Services them from a thread-partitioned word array: physical address = {thread, addr}, so each thread owns half of the memory.
- Returns read data in request order through a fixed-latency pipeline and an output FIFO with backpressure. The processor is the initiator; this block is the responder.

---
 rtl/thread_mem_responder.sv | 143 ++++++++++++++
 tb/tb_thread_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/thread_mem_responder.sv
// thread_mem_responder
//   Memory-side responder for the two-thread stack processor's load/store/fetch
//   port. Requests are tagged with a thread ID and serviced from a word array
//   split by thread: physical address = {thread, addr}. Reads return in
//   acceptance order through a fixed-latency pipeline and an output FIFO.
//   Admission is credit based (FIFO entries minus reads already in flight), so
//   the FIFO can never overflow and no read is ever dropped.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready is independent of req_valid)
//   req_thread, req_we    thread ID, 1 = write / 0 = read
//   req_addr, req_wdata   word address within the thread's half, write data
//   rsp_valid/rsp_ready   response handshake (FIFO head)
//   rsp_thread, rsp_data  thread ID and read data of the head response
//   rd_count, wr_count    accepted read / write counters
//
// Optional feature
//   THREAD_MEM_RESPONDER_STATS_EN : builds saturating 16-bit rd_count/wr_count.
//   Left undefined, both outputs are tied to 0 and no counter logic exists.
//
// Parameters
//   ADDR_W     per-thread word address width (array = 2^(ADDR_W+1) x 16)
//   LATENCY    read acceptance edge to FIFO push edge, 1..4
//   FIFO_DEPTH response FIFO entries, power of two, >= LATENCY
module thread_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_thread,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_thread,
  output logic [15:0]       rsp_data,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int STAGES = LATENCY - 1;          // vld_pipe[STAGES] feeds the FIFO
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PW     = AW + 1;               // extra MSB separates full from empty
  localparam int CW     = PW + 1;               // occupancy sum width
  localparam int MW     = ADDR_W + 1;           // physical word address width

  typedef struct packed {
    logic        thread;
    logic [15:0] data;
  } rsp_t;

  logic [15:0]   mem [0:(2**MW)-1];
  logic [MW-1:0] paddr;

  logic [STAGES:0] vld_pipe;
  rsp_t            pipe_q [0:STAGES];
  rsp_t            fifo_q [0:FIFO_DEPTH-1];
  rsp_t            head;
  logic [PW-1:0]   wptr, rptr, fifo_cnt;
  logic [CW-1:0]   inflight, occupancy;

  logic accept, rd_acc, wr_acc, push, pop;

  assign paddr  = {req_thread, req_addr};
  assign accept = req_valid & req_ready;
  assign rd_acc = accept & ~req_we;
  assign wr_acc = accept &  req_we;
  assign push   = vld_pipe[STAGES];
  assign pop    = rsp_valid & rsp_ready;

  // Credits: every read already admitted, whether still in the pipeline or
  // sitting in the FIFO, holds one FIFO entry. A pop frees its credit on the
  // following cycle since occupancy is built only from registered state.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  assign fifo_cnt  = wptr - rptr;
  assign occupancy = CW'(fifo_cnt) + inflight;
  assign req_ready = ~reset & (occupancy < CW'(FIFO_DEPTH));

  // Array, read pipeline data and FIFO storage carry no reset: the array must
  // survive reset, and the other payload is qualified by reset valid state.
  // A write on one edge is visible to a read on the next because the read
  // samples the array at its own acceptance edge.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[paddr] <= req_wdata;
    if (rd_acc) begin
      pipe_q[0].thread <= req_thread;
      pipe_q[0].data   <= mem[paddr];
    end
    for (int i = 1; i <= STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    if (push) fifo_q[wptr[AW-1:0]] <= pipe_q[STAGES];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
    end
  end

  // Head is gated with rsp_valid so the outputs read 0 whenever the FIFO is
  // empty, including immediately on reset assertion.
  assign head       = fifo_q[rptr[AW-1:0]];
  assign rsp_valid  = (wptr != rptr);
  assign rsp_data   = rsp_valid ? head.data : 16'h0000;
  assign rsp_thread = rsp_valid & head.thread;

`ifdef THREAD_MEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_acc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_acc && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_thread_mem_responder.sv
// Directed bench for thread_mem_responder (ADDR_W=16, LATENCY=2, FIFO_DEPTH=4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_thread_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_thread = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_thread;
  logic [15:0] rsp_data, rd_count, wr_count;

  int checks = 0;
  int failures = 0;

  thread_mem_responder #(.ADDR_W(16), .LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_thread(req_thread),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_thread(rsp_thread),
    .rsp_data(rsp_data), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic t, input logic we,
                     input logic [15:0] a, input logic [15:0] d);
    req_valid = v; req_thread = t; req_we = we; req_addr = a; req_wdata = d;
  endtask

  // Presents a write for the next rising edge; caller's next drive replaces it.
  task automatic wr(input logic t, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    drv(1'b1, t, 1'b1, a, d);
    chk("wr_ready", req_ready, 1);
  endtask

  task automatic read_chk(input string tag, input logic t, input logic [15:0] a,
                          input logic [15:0] exp);
    @(negedge clk);
    drv(1'b1, t, 1'b0, a, 16'h0);
    rsp_ready = 1'b1;
    chk({tag, "_ready"}, req_ready, 1);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_thread"}, rsp_thread, t);
  endtask

  logic [16:0] q[$];
  int acc, issued, got, seen;
  logic [15:0] exp_rd, exp_wr;

  initial begin
    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_thread", rsp_thread, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // ---- write then back-to-back read, latency 2
    drv(1'b1, 1'b0, 1'b1, 16'h0005, 16'hBEEF);
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("lat_a0_valid", rsp_valid, 0);
    @(negedge clk);
    chk("lat_a1_valid", rsp_valid, 0);
    @(negedge clk);
    chk("lat_a2_valid", rsp_valid, 1);
    chk("lat_data", rsp_data, 16'hBEEF);
    chk("lat_thread", rsp_thread, 0);
    @(negedge clk);
    chk("lat_popped", rsp_valid, 0);

    // ---- thread partitioning and order, held output while stalled
    rsp_ready = 1'b0;
    wr(1'b0, 16'h0003, 16'h1111);
    wr(1'b1, 16'h0003, 16'h2222);
    @(negedge clk); drv(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0);
    @(negedge clk); drv(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0);
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("part_h0_data", rsp_data, 16'h2222);
    chk("part_h0_thread", rsp_thread, 1);
    @(negedge clk);
    chk("part_hold_valid", rsp_valid, 1);
    chk("part_hold_data", rsp_data, 16'h2222);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("part_h1_data", rsp_data, 16'h1111);
    chk("part_h1_thread", rsp_thread, 0);
    @(negedge clk);
    chk("part_empty", rsp_valid, 0);

    // ---- fill to credit limit with rsp_ready low, then drain
    for (int i = 0; i < 6; i++) wr(1'b0, 16'(10 + i), 16'(16'hA000 + i));
    rsp_ready = 1'b0;
    q.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv(1'b1, 1'b0, 1'b0, 16'(10 + acc), 16'h0);
      if (req_ready) begin
        q.push_back({1'b0, 16'(16'hA000 + acc)});
        acc++;
      end
    end
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("full_accepted", acc, 4);
    chk("full_ready_low", req_ready, 0);
    repeat (3) @(negedge clk);
    chk("full_still_low", req_ready, 0);
    chk("full_valid", rsp_valid, 1);
    chk("full_d0", rsp_data, q.pop_front());
    rsp_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 0) chk("full_ready_after_pop", req_ready, 1);
      if (rsp_valid) chk("full_drain", rsp_data, q.pop_front());
    end
    chk("full_drain_all", q.size(), 0);
    @(negedge clk);
    chk("full_empty", rsp_valid, 0);

    // ---- 20-read burst with random backpressure, scoreboarded
    for (int i = 0; i < 20; i++) wr(1'(i % 2), 16'(50 + i), 16'(16'h3000 + i * 7));
    q.delete();
    issued = 0; got = 0;
    for (int c = 0; c < 400 && got < 20; c++) begin
      @(negedge clk);
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready) begin
        chk("burst_rsp", {rsp_thread, rsp_data}, q.pop_front());
        got++;
      end
      if (issued < 20) begin
        drv(1'b1, 1'(issued % 2), 1'b0, 16'(50 + issued), 16'h0);
        if (req_ready) begin
          q.push_back({1'(issued % 2), 16'(16'h3000 + issued * 7)});
          issued++;
        end
      end else begin
        drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    chk("burst_count", got, 20);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("burst_empty", rsp_valid, 0);

    // ---- reset with reads in flight; array and last write survive
    wr(1'b1, 16'd100, 16'h5A5A);
    rsp_ready = 1'b0;
    @(negedge clk); drv(1'b1, 1'b1, 1'b0, 16'd100, 16'h0);
    @(negedge clk); drv(1'b1, 1'b1, 1'b0, 16'd100, 16'h0);
    @(negedge clk); drv(1'b1, 1'b1, 1'b0, 16'd100, 16'h0);
    @(negedge clk); drv(1'b1, 1'b0, 1'b1, 16'd200, 16'hC3C3);
    chk("mid_wr_ready", req_ready, 1);
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("mid_valid_pre", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_async_valid", rsp_valid, 0);
    chk("mid_async_data", rsp_data, 0);
    chk("mid_async_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_no_stale", seen, 0);
    read_chk("mid_rd_last_wr", 1'b0, 16'd200, 16'hC3C3);
    read_chk("mid_rd_persist", 1'b1, 16'd100, 16'h5A5A);

    // ---- statistics: 5 reads, 3 writes since reset
    read_chk("st_r3", 1'b0, 16'd3, 16'h1111);
    read_chk("st_r4", 1'b1, 16'd3, 16'h2222);
    read_chk("st_r5", 1'b0, 16'd5, 16'hBEEF);
    wr(1'b0, 16'd300, 16'h0001);
    wr(1'b0, 16'd301, 16'h0002);
    wr(1'b1, 16'd302, 16'h0003);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef THREAD_MEM_RESPONDER_STATS_EN
    exp_rd = 16'd5; exp_wr = 16'd3;
`else
    exp_rd = 16'd0; exp_wr = 16'd0;
`endif
    chk("stat_rd_count", rd_count, exp_rd);
    chk("stat_wr_count", wr_count, exp_wr);
    read_chk("st_wr_back", 1'b1, 16'd302, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
